sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one asynchronous 32-bit SRAM between the pipeline's instruction-fetch port and its data (load/store) port.
- Serialises requests, sequences SRAM control strobes over a programmable number of wait cycles, and returns read data with a one-cycle ready pulse.
- The pipeline uses the inverted ready signals as IF/MEM stall inputs.
- Data port has fixed priority, because it belongs to the older instruction.

Parameters:
- WAIT_CYCLES, 2: cycles that ce_n/oe_n or we_n stay asserted per access. Legal range 1..15.
- ADDR_W, 20: SRAM word-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  instruction fetch request; held until if_ready
- if_addr  in  32  fetch byte address, word-aligned
- if_rdata  out  32  fetched word; valid when if_ready=1
- if_ready  out  1  one-cycle pulse: fetch complete
- d_req  in  1  data request; held with all d_* inputs until d_ready
- d_we  in  1  1=store, 0=load
- d_byte  in  1  1=byte access (lb/sb), 0=word
- d_addr  in  32  data byte address
- d_wdata  in  32  store data; for a byte store, bits [7:0] are used
- d_rdata  out  32  load result; valid when d_ready=1
- d_ready  out  1  one-cycle pulse: data access complete
- sram_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- sram_wdata  out  32  write data to SRAM
- sram_wdata_oe  out  1  1=drive the data bus; the top level builds the tri-state
- sram_rdata  in  32  SRAM read data
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low
- sram_be_n  out  4  byte enables, active-low

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, counter=0
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_wdata_oe=0
  - sram_addr=0, sram_wdata=0
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0
- Reset mid-access abandons the access immediately; no ready pulse is issued for it.
- All SRAM outputs are registered; no combinational path from *_req to sram_*.
- FSM states:
  - IDLE
    - If d_req: latch grant=DATA plus address/we/byte/wdata; go to ACCESS.
    - Else if if_req: latch grant=INST; go to ACCESS.
    - Else stay.
    - When d_req and if_req arrive in the same cycle, DATA wins. INST waits and is served on the next IDLE decision.
  - ACCESS
    - Outputs: sram_ce_n=0.
    - Read: sram_oe_n=0, sram_we_n=1.
    - Write: sram_we_n=0, sram_oe_n=1, sram_wdata_oe=1.
    - Counter counts 0..WAIT_CYCLES-1.
    - On the last count, a read registers sram_rdata into the capture register. Go to DONE.
  - DONE
    - sram_ce_n/oe_n/we_n=1.
    - A write keeps sram_addr, sram_wdata and sram_wdata_oe=1 for this cycle as hold time.
    - Pulse the granted port's ready for exactly one cycle. Return to IDLE.
- Latency from req seen in IDLE to ready pulse: WAIT_CYCLES+2 cycles.
  - With default WAIT_CYCLES=2 this is 4 cycles.
  - Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
  - A request still high in the cycle after ready is treated as a new request. Requesters must drop or update req in the cycle after ready.
- Byte lanes, with lane = d_addr[1:0]:
  - Word access: sram_be_n=4'h0, sram_wdata=d_wdata, d_rdata=sram_rdata. addr[1:0] is ignored.
  - Byte store: sram_be_n=~(4'b0001<<lane); d_wdata[7:0] is replicated to all four lanes.
  - Byte load: sram_be_n=~(4'b0001<<lane). d_rdata = sign-extended byte sram_rdata[8*lane+7:8*lane].
  - Instruction fetch: always word, sram_be_n=4'h0.
- Read-data outputs:
  - if_rdata/d_rdata hold their last value until the next completion of the same port.
  - The port not granted never sees a ready pulse.
- Request dropped before service:
  - req deasserted while in IDLE: nothing is granted.
  - req deasserted after grant: the access completes and ready still pulses.
  - Requester misbehaviour is not flagged.

Test Plan:
- Single word read: if_req, if_addr=32'h8000_0010, sram_rdata=32'h2408_0001 → sram_addr=20'h00004 (addr[21:2]); ce_n/oe_n low 2 cycles; if_ready pulses on the 4th cycle after req; if_rdata=32'h2408_0001.
- Simultaneous requests: if_req and d_req (load, addr 32'h8040_0000) asserted in the same cycle → data served first, d_ready at cycle 4; fetch served next, if_ready at cycle 8; no overlap of ce_n low periods.
- Byte store: d_we=1, d_byte=1, d_addr=32'h8040_0003, d_wdata=32'h0000_00A5 → sram_be_n=4'b0111, sram_wdata=32'hA5A5_A5A5, we_n low 2 cycles, data bus driven one extra cycle; d_ready=1 once.
- Byte load sign-extension: d_addr lane 2, sram_rdata=32'h0080_0000 → d_rdata=32'hFFFF_FF80. Lane 0 with 8'h7F → 32'h0000_007F.
- Reset mid-access: assert rst during ACCESS → all strobes high and be_n=4'hF in the same cycle, no ready pulse; after release, a new request completes normally.
- WAIT_CYCLES=1 and 15 builds: latency measured 3 and 17 cycles respectively; back-to-back word fetches complete every WAIT_CYCLES+2 cycles.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Shares one asynchronous SRAM between the fetch port and the data port; the data port wins ties.
// Latency: WAIT_CYCLES+2 cycles from req seen in IDLE to the ready pulse, counting the request cycle.
// Backpressure: a req is held until its one-cycle ready pulse; the pipeline stalls on the inverted ready.
module sram_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_wdata_oe,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       grant_d;
    logic       is_we;
    logic       is_byte;
    logic [1:0] lane;
    logic [7:0] rbyte;

    logic unused;
    assign unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

    always_comb begin
        rbyte = sram_rdata[7:0];
        case (lane)
            2'd1:    rbyte = sram_rdata[15:8];
            2'd2:    rbyte = sram_rdata[23:16];
            2'd3:    rbyte = sram_rdata[31:24];
            default: rbyte = sram_rdata[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            grant_d       <= 1'b0;
            is_we         <= 1'b0;
            is_byte       <= 1'b0;
            lane          <= '0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_be_n     <= 4'hF;
            sram_wdata_oe <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            if_ready      <= 1'b0;
            d_ready       <= 1'b0;
            if_rdata      <= '0;
            d_rdata       <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    sram_wdata_oe <= 1'b0;
                    sram_be_n     <= 4'hF;
                    // Data port first: it belongs to the older instruction.
                    if (d_req) begin
                        grant_d       <= 1'b1;
                        is_we         <= d_we;
                        is_byte       <= d_byte;
                        lane          <= d_addr[1:0];
                        sram_addr     <= d_addr[ADDR_W+1:2];
                        sram_wdata    <= d_byte ? {4{d_wdata[7:0]}} : d_wdata;
                        sram_be_n     <= d_byte ? ~(4'b0001 << d_addr[1:0]) : 4'h0;
                        sram_ce_n     <= 1'b0;
                        sram_oe_n     <= d_we;
                        sram_we_n     <= ~d_we;
                        sram_wdata_oe <= d_we;
                        cnt           <= '0;
                        state         <= ACCESS;
                    end else if (if_req) begin
                        grant_d       <= 1'b0;
                        is_we         <= 1'b0;
                        is_byte       <= 1'b0;
                        lane          <= '0;
                        sram_addr     <= if_addr[ADDR_W+1:2];
                        sram_be_n     <= 4'h0;
                        sram_ce_n     <= 1'b0;
                        sram_oe_n     <= 1'b0;
                        sram_we_n     <= 1'b1;
                        cnt           <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == LAST) begin
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (grant_d) begin
                            d_ready <= 1'b1;
                            if (!is_we)
                                d_rdata <= is_byte ? {{24{rbyte[7]}}, rbyte} : sram_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_rdata;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    // Address, data and bus drive were held through this cycle for write hold time.
                    sram_wdata_oe <= 1'b0;
                    sram_be_n     <= 4'hF;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed and randomized checks of the SRAM arbiter against a word-array memory model.
module tb_sram_bus_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, d_byte;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, sram_wdata, sram_rdata;
    logic        if_ready, d_ready, sram_wdata_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;

    logic [31:0] sram_mem [16];
    logic [31:0] ref_mem  [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    // Asynchronous SRAM: reads follow the address, enabled byte lanes are written while we_n is low.
    assign sram_rdata = sram_mem[sram_addr[3:0]];
    always @(negedge clk) begin
        if (pl_en)
            sram_mem[pl_idx] <= pl_val;
        else if (!sram_ce_n && !sram_we_n)
            for (int i = 0; i < 4; i++)
                if (!sram_be_n[i]) sram_mem[sram_addr[3:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
    end

    // Fetch-only instances at the extreme wait settings, sharing one request line.
    logic        f_req = 1'b0;
    logic [31:0] f_rdata = 32'hCAFE_F00D;
    logic [31:0] r1, dr1, sw1, r15, dr15, sw15;
    logic        y1, dy1, oe1, ce1, oen1, we1, y15, dy15, oe15, ce15, oen15, we15;
    logic [19:0] sa1, sa15;
    logic [3:0]  be1, be15;

    sram_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20)) u_w1 (
        .clk(clk), .rst(rst), .if_req(f_req), .if_addr(32'h0000_0040), .if_rdata(r1), .if_ready(y1),
        .d_req(1'b0), .d_we(1'b0), .d_byte(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(dr1), .d_ready(dy1), .sram_addr(sa1), .sram_wdata(sw1), .sram_wdata_oe(oe1),
        .sram_rdata(f_rdata), .sram_ce_n(ce1), .sram_oe_n(oen1), .sram_we_n(we1), .sram_be_n(be1)
    );

    sram_bus_arbiter #(.WAIT_CYCLES(15), .ADDR_W(20)) u_w15 (
        .clk(clk), .rst(rst), .if_req(f_req), .if_addr(32'h0000_0040), .if_rdata(r15), .if_ready(y15),
        .d_req(1'b0), .d_we(1'b0), .d_byte(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(dr15), .d_ready(dy15), .sram_addr(sa15), .sram_wdata(sw15), .sram_wdata_oe(oe15),
        .sram_rdata(f_rdata), .sram_ce_n(ce15), .sram_oe_n(oen15), .sram_we_n(we15), .sram_be_n(be15)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_idx = 4'(idx);
        pl_val = val;
        pl_en  = 1'b1;
        @(negedge clk);
        #1 pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    function automatic logic [31:0] sext(input logic [31:0] w, input logic [1:0] l);
        logic [7:0] b;
        b = 8'(w >> (8 * l));
        return {{24{b[7]}}, b};
    endfunction

    // One complete transaction; expected values come from ref_mem, which stores update.
    task automatic do_access(input bit is_d, input bit we, input bit byt,
                             input logic [31:0] addr, input logic [31:0] wd);
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd, other_rd;
        int          idx, n, ce_low;
        bit          seen, other;
        idx    = int'(addr[5:2]);
        exp_be = 4'h0;
        if (is_d && byt)
            for (int i = 0; i < 4; i++) exp_be[i] = (i != int'(addr[1:0]));
        exp_wd   = byt ? {4{wd[7:0]}} : wd;
        exp_rd   = (is_d && byt) ? sext(ref_mem[idx], addr[1:0]) : ref_mem[idx];
        other_rd = is_d ? if_rdata : d_rdata;
        @(posedge clk);
        #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_byte = byt; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0; ce_low = 0; seen = 0; other = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!sram_ce_n) ce_low++;
            if (n == 1) begin
                chk("sram_addr", 32'(sram_addr), 32'(addr[21:2]));
                chk("be_n", 32'(sram_be_n), 32'(exp_be));
                chk("oe_n", 32'(sram_oe_n), 32'(we));
                chk("we_n", 32'(sram_we_n), 32'(!we));
                chk("wdata_oe", 32'(sram_wdata_oe), 32'(we));
                if (we) chk("sram_wdata", sram_wdata, exp_wd);
            end
            if (is_d ? if_ready : d_ready) other = 1;
            seen = is_d ? d_ready : if_ready;
        end
        chk("latency", n + 1, W + 2);
        chk("strobe_cycles", ce_low, W);
        if (we) begin
            chk("hold_wdata_oe", 32'(sram_wdata_oe), 32'h1);
            chk("hold_we_n", 32'(sram_we_n), 32'h1);
            chk("hold_wdata", sram_wdata, exp_wd);
        end else begin
            chk(is_d ? "d_rdata" : "if_rdata", is_d ? d_rdata : if_rdata, exp_rd);
        end
        chk("other_ready", 32'(other), 32'h0);
        chk("other_rdata_hold", is_d ? if_rdata : d_rdata, other_rd);
        if_req = 1'b0;
        d_req  = 1'b0;
        if (is_d && we) begin
            if (byt) ref_mem[idx][8*addr[1:0] +: 8] = wd[7:0];
            else     ref_mem[idx] = wd;
        end
        @(posedge clk);
        #1;
        chk("ready_one_cycle", 32'({if_ready, d_ready}), 32'h0);
    endtask

    initial begin
        int td, ti, k1, k15, t1 [3], t15 [3], kind;
        bit overlap;
        logic [31:0] a;
        rst = 1'b1;
        if_req = 0; d_req = 0; d_we = 0; d_byte = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);

        chk("rst_ce_n", 32'(sram_ce_n), 32'h1);
        chk("rst_oe_we", 32'({sram_oe_n, sram_we_n}), 32'h3);
        chk("rst_be_n", 32'(sram_be_n), 32'hF);
        chk("rst_wdata_oe", 32'(sram_wdata_oe), 32'h0);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_wdata", sram_wdata, 32'h0);
        chk("rst_ready", 32'({if_ready, d_ready}), 32'h0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word fetch.
        preload(4, 32'h2408_0001);
        do_access(0, 0, 0, 32'h8000_0010, 32'h0);

        // Simultaneous requests: data first, fetch one access later.
        @(posedge clk);
        #1;
        d_req = 1; d_we = 0; d_byte = 0; d_addr = 32'h8040_0000;
        if_req = 1; if_addr = 32'h8000_0014;
        td = 0; ti = 0; overlap = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (d_ready) begin if (td == 0) td = n; d_req = 0; end
            if (if_ready) begin if (ti == 0) ti = n; if_req = 0; end
            if ((n == W + 1 || n == W + 2) && !sram_ce_n) overlap = 1;
            if (d_ready && if_ready) overlap = 1;
        end
        chk("sim_d_latency", td + 1, W + 2);
        chk("sim_if_latency", ti + 1, 2 * (W + 2));
        chk("sim_no_overlap", 32'(overlap), 32'h0);
        chk("sim_d_rdata", d_rdata, ref_mem[0]);
        chk("sim_if_rdata", if_rdata, ref_mem[5]);

        // Byte store, then byte loads with sign extension.
        do_access(1, 1, 1, 32'h8040_0003, 32'h0000_00A5);
        do_access(1, 0, 0, 32'h8040_0000, 32'h0);
        preload(1, 32'h0080_0000);
        do_access(1, 0, 1, 32'h8040_0006, 32'h0);
        chk("lb_neg", d_rdata, 32'hFFFF_FF80);
        preload(2, 32'h0000_007F);
        do_access(1, 0, 1, 32'h8040_0008, 32'h0);
        chk("lb_pos", d_rdata, 32'h0000_007F);

        // Reset in the middle of a load.
        @(posedge clk);
        #1;
        d_req = 1; d_we = 0; d_byte = 0; d_addr = 32'h0000_0010;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_ce_n", 32'(sram_ce_n), 32'h0);
        rst = 1'b1;
        #1;
        chk("mid_rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
        chk("mid_rst_be_n", 32'(sram_be_n), 32'hF);
        chk("mid_rst_ready", 32'({if_ready, d_ready}), 32'h0);
        d_req = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'({if_ready, d_ready}), 32'h0);
        chk("post_rst_ce_n", 32'(sram_ce_n), 32'h1);
        do_access(0, 0, 0, 32'h0000_0020, 32'h0);

        // Randomized mix of fetches, loads and stores.
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            if (kind == 0)      do_access(0, 0, 0, a & 32'hFFFF_FFFC, 32'h0);
            else if (kind == 1) do_access(1, 0, 1'($urandom_range(0, 1)), a, 32'h0);
            else                do_access(1, 1, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Extreme wait settings with a fetch request held high back to back.
        k1 = 0; k15 = 0;
        for (int i = 0; i < 3; i++) begin t1[i] = 0; t15[i] = 0; end
        @(posedge clk);
        #1 f_req = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (y1 && k1 < 3) begin t1[k1] = e; k1++; end
            if (y15 && k15 < 3) begin t15[k15] = e; k15++; end
        end
        f_req = 1'b0;
        chk("w1_latency", t1[0] + 1, 3);
        chk("w1_period_a", t1[1] - t1[0], 3);
        chk("w1_period_b", t1[2] - t1[1], 3);
        chk("w1_rdata", r1, 32'hCAFE_F00D);
        chk("w15_latency", t15[0] + 1, 17);
        chk("w15_period_a", t15[1] - t15[0], 17);
        chk("w15_period_b", t15[2] - t15[1], 17);
        chk("w15_rdata", r15, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
